if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the IF/ID pipeline register. Owns the PC, issues
//  single-outstanding reads to instruction memory, and delivers {pc, instr} to IF/ID with a
//  load/flush pair. Absorbs hazard stalls in a one-entry hold register and handles EX-stage
//  redirects, including discarding an in-flight response.
// PARAMETERS
//  WIDTH      32             address/data width
//  RESET_PC   32'h6000_0000  PC after reset
//  CNT_WIDTH  32             perf counter width (IF_FETCH_PERF_EN only)
// PORTS
//  clk            in   1        clock, rising edge
//  rst            in   1        asynchronous, active-low reset
//  stall_i        in   1        hazard unit: IF/ID must not accept a new instruction
//  redirect_i     in   1        EX: taken branch/jump this cycle
//  redirect_pc_i  in   WIDTH    redirect target
//  inst_read_o    out  1        imem read request
//  inst_addr_o    out  WIDTH    imem address; stable while inst_read_o=1 until inst_resp_i
//  inst_resp_i    in   1        imem response valid (one cycle)
//  inst_rdata_i   in   WIDTH    imem read data, valid with inst_resp_i
//  if_pc_o        out  WIDTH    pc of delivered instruction -> IF/ID pc input
//  if_instr_o     out  WIDTH    delivered instruction -> IF/ID instr input
//  ifid_load_o    out  1        IF/ID load enable
//  ifid_flush_o   out  1        IF/ID flush
// BEHAVIOUR
//  - Regs: pc (next fetch addr), req_addr (drives inst_addr_o), hold_instr, hold_pc, state.
//  - Reset (rst=0, async): state=FETCH, pc=req_addr=RESET_PC, hold regs=0; all outputs 0 while
//    rst=0. First cycle after release: inst_read_o=1, inst_addr_o=RESET_PC.
//  - States: FETCH (request outstanding, inst_read_o=1), HOLD (instr captured, inst_read_o=0),
//    KILL (inst_read_o=1 with stale req_addr; response to be dropped).
//  - Priority per cycle: redirect_i > inst_resp_i > stall_i release.
//  - FETCH, resp, !stall, !redirect: if_pc_o=req_addr, if_instr_o=inst_rdata_i, ifid_load_o=1
//    same cycle (combinational pass-through); pc,req_addr <= req_addr+4; stay FETCH.
//  - FETCH, resp, stall: hold_pc<=req_addr, hold_instr<=rdata, pc<=req_addr+4; ->HOLD; load=0.
//  - HOLD, !stall: if_pc_o/if_instr_o from hold regs, ifid_load_o=1; req_addr<=pc; ->FETCH.
//    HOLD, stall: outputs hold, load=0, no memory traffic.
//  - redirect_i (any state): ifid_flush_o=1, ifid_load_o=0, pc<=redirect_pc_i & ~3 (low 2 bits
//    forced 0). FETCH w/o resp -> KILL (req_addr unchanged, read stays high). FETCH with resp
//    same cycle -> response dropped, req_addr<=target, ->FETCH. HOLD -> hold dropped,
//    req_addr<=target, ->FETCH. KILL -> pc updated again, stay KILL.
//  - KILL, resp: data dropped, load=0, req_addr<=pc, ->FETCH.
//  - ifid_load_o and ifid_flush_o never both 1. if_pc_o/if_instr_o are 0 when load=0 and not HOLD.
//  - PC arithmetic modulo 2^WIDTH: 32'hFFFF_FFFC+4 wraps to 0, no error.
//  - Throughput: one instr per imem response; no speculation beyond +4.
// CONFIGURATION
//  IF_FETCH_PERF_EN defined: adds outputs fetch_cnt_o, stall_cnt_o [CNT_WIDTH]; fetch_cnt
//  increments per ifid_load_o=1, stall_cnt per cycle in HOLD with stall_i=1; both reset to 0,
//  saturate at all-ones. Undefined: ports and counters absent; core behaviour identical.
// TESTING
//  1 Reset release, resp every 2nd cycle, rdata=0x00000013 -> loads with pc 0x60000000,
//    0x60000004, 0x60000008; inst_addr_o stable between responses.
//  2 stall_i=1 when resp for 0x60000004 arrives, held 3 cycles -> HOLD, load=0 x3, then load=1
//    with pc 0x60000004; next request addr 0x60000008.
//  3 redirect_i to 0x60000102 while request outstanding -> flush=1, KILL, next resp dropped,
//    following request at 0x60000100.
//  4 redirect_i same cycle as resp -> flush=1, load=0, next inst_addr_o = target.
//  5 rst asserted mid-FETCH and mid-HOLD -> outputs 0 immediately; after release addr=RESET_PC.
//  6 PC=0xFFFFFFFC delivered -> next addr 0x00000000; with IF_FETCH_PERF_EN counters match.

Source files
------------

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : IF stage feeding IF/ID. Owns the PC, single-outstanding imem reads,
//            a one-entry hold slot for stalls and redirect/kill handling.
//            Optional perf counters enabled by defining IF_FETCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = 32'h6000_0000,
  parameter int               CNT_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             inst_read_o,
  output logic [WIDTH-1:0] inst_addr_o,
  input  logic             inst_resp_i,
  input  logic [WIDTH-1:0] inst_rdata_i,
  output logic [WIDTH-1:0] if_pc_o,
  output logic [WIDTH-1:0] if_instr_o,
  output logic             ifid_load_o,
  output logic             ifid_flush_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] fetch_cnt_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_KILL  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_pc_inc = WIDTH'(4);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, r_req_addr, r_hold_pc, r_hold_instr;
  logic [WIDTH-1:0] w_pc_nxt, w_req_addr_nxt, w_hold_pc_nxt, w_hold_instr_nxt;
  logic [WIDTH-1:0] w_target, w_seq_addr;

  assign w_target   = {redirect_pc_i[WIDTH-1:2], 2'b00};
  assign w_seq_addr = r_req_addr + c_pc_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_hold_instr <= w_hold_instr_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_addr_nxt   = r_req_addr;
    w_hold_pc_nxt    = r_hold_pc;
    w_hold_instr_nxt = r_hold_instr;
    inst_read_o      = 1'b0;
    inst_addr_o      = '0;
    if_pc_o          = '0;
    if_instr_o       = '0;
    ifid_load_o      = 1'b0;
    ifid_flush_o     = 1'b0;
    case (r_state)
      ST_FETCH: begin
        inst_read_o = 1'b1;
        inst_addr_o = r_req_addr;
        if (redirect_i) begin
          ifid_flush_o = 1'b1;
          w_pc_nxt     = w_target;
          // A response landing with the redirect is simply dropped; otherwise
          // the in-flight request must be drained in KILL.
          if (inst_resp_i) w_req_addr_nxt = w_target;
          else             w_state_nxt    = ST_KILL;
        end else if (inst_resp_i) begin
          w_pc_nxt = w_seq_addr;
          if (stall_i) begin
            w_hold_pc_nxt    = r_req_addr;
            w_hold_instr_nxt = inst_rdata_i;
            w_state_nxt      = ST_HOLD;
          end else begin
            if_pc_o        = r_req_addr;
            if_instr_o     = inst_rdata_i;
            ifid_load_o    = 1'b1;
            w_req_addr_nxt = w_seq_addr;
          end
        end
      end
      ST_HOLD: begin
        if_pc_o    = r_hold_pc;
        if_instr_o = r_hold_instr;
        if (redirect_i) begin
          ifid_flush_o   = 1'b1;
          w_pc_nxt       = w_target;
          w_req_addr_nxt = w_target;
          w_state_nxt    = ST_FETCH;
        end else if (!stall_i) begin
          ifid_load_o    = 1'b1;
          w_req_addr_nxt = r_pc;
          w_state_nxt    = ST_FETCH;
        end
      end
      ST_KILL: begin
        inst_read_o = 1'b1;
        inst_addr_o = r_req_addr;
        if (redirect_i) begin
          ifid_flush_o = 1'b1;
          w_pc_nxt     = w_target;
          if (inst_resp_i) begin
            w_req_addr_nxt = w_target;
            w_state_nxt    = ST_FETCH;
          end
        end else if (inst_resp_i) begin
          w_req_addr_nxt = r_pc;
          w_state_nxt    = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_FETCH;
    endcase
    // Everything facing the pipeline and memory is quiet while reset is held.
    if (!rst) begin
      inst_read_o  = 1'b0;
      inst_addr_o  = '0;
      if_pc_o      = '0;
      if_instr_o   = '0;
      ifid_load_o  = 1'b0;
      ifid_flush_o = 1'b0;
    end
  end

`ifdef IF_FETCH_PERF_EN
  logic [CNT_WIDTH-1:0] r_fetch_cnt, r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (ifid_load_o && (r_fetch_cnt != '1))
        r_fetch_cnt <= r_fetch_cnt + CNT_WIDTH'(1);
      if ((r_state == ST_HOLD) && stall_i && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign stall_cnt_o = r_stall_cnt;
`else
  // Performance counters not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// Testbench for if_fetch_unit: directed scenarios with literal checks followed by
// randomized traffic compared every cycle against a transaction-level model.
module tb_if_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h6000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0, redirect_i = 1'b0, inst_resp_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, inst_rdata_i = '0;
  logic        inst_read_o, ifid_load_o, ifid_flush_o;
  logic [31:0] inst_addr_o, if_pc_o, if_instr_o;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_o, stall_cnt_o;
`endif

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .inst_read_o(inst_read_o), .inst_addr_o(inst_addr_o),
    .inst_resp_i(inst_resp_i), .inst_rdata_i(inst_rdata_i), .if_pc_o(if_pc_o),
    .if_instr_o(if_instr_o), .ifid_load_o(ifid_load_o), .ifid_flush_o(ifid_flush_o)
`ifdef IF_FETCH_PERF_EN
    , .fetch_cnt_o(fetch_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: next fetch PC, address of the outstanding request, whether that
  // request's answer is stale, and a one-deep queue of parked instructions.
  logic [31:0] m_pc, m_addr;
  bit          m_drop;
  logic [63:0] hold_q[$];
  logic [31:0] m_fetch_cnt, m_stall_cnt;

  // Last observed DUT outputs, used by directed literal checks.
  logic        last_load, last_flush, last_read;
  logic [31:0] last_pc, last_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    m_addr = RST_PC;
    m_drop = 0;
    hold_q.delete();
    m_fetch_cnt = 0;
    m_stall_cnt = 0;
  endtask

  // One clock cycle: drive at negedge, compare combinational outputs, advance model.
  task automatic step(input bit rv, input bit st, input bit rd, input logic [31:0] rpc,
                      input bit rs, input logic [31:0] rdat);
    logic        e_read, e_load, e_flush;
    logic [31:0] e_addr, e_pc, e_ins, tgt;
    bit          holding;
    @(negedge clk);
    rst = rv;
    holding = (hold_q.size() != 0);
    e_read = rv && !holding;
    stall_i = st;
    redirect_i = rd;
    redirect_pc_i = rpc;
    inst_resp_i = rs && e_read;
    inst_rdata_i = rdat;
    #2;
    e_addr = e_read ? m_addr : 32'h0;
    e_load = 0; e_flush = 0; e_pc = 0; e_ins = 0;
    if (rv) begin
`ifdef IF_FETCH_PERF_EN
      chk("fetch_cnt", fetch_cnt_o, m_fetch_cnt);
      chk("stall_cnt", stall_cnt_o, m_stall_cnt);
`endif
      if (holding) begin
        e_pc = hold_q[0][63:32];
        e_ins = hold_q[0][31:0];
        if (st && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
      end
      tgt = rpc & 32'hFFFF_FFFC;
      if (rd) begin
        e_flush = 1;
        m_pc = tgt;
        if (holding) begin
          hold_q.delete();
          m_addr = tgt;
          m_drop = 0;
        end else if (inst_resp_i) begin
          m_addr = tgt;
          m_drop = 0;
        end else begin
          m_drop = 1;
        end
      end else if (holding) begin
        if (!st) begin
          e_load = 1;
          void'(hold_q.pop_front());
          m_addr = m_pc;
        end
      end else if (inst_resp_i) begin
        if (m_drop) begin
          m_drop = 0;
          m_addr = m_pc;
        end else if (st) begin
          hold_q.push_back({m_addr, rdat});
          m_pc = m_addr + 32'd4;
        end else begin
          e_load = 1;
          e_pc = m_addr;
          e_ins = rdat;
          m_pc = m_addr + 32'd4;
          m_addr = m_addr + 32'd4;
        end
      end
      if (e_load && m_fetch_cnt != 32'hFFFF_FFFF) m_fetch_cnt++;
    end else begin
`ifdef IF_FETCH_PERF_EN
      chk("fetch_cnt_rst", fetch_cnt_o, 32'h0);
      chk("stall_cnt_rst", stall_cnt_o, 32'h0);
`endif
    end
    chk("inst_read", {31'b0, inst_read_o}, {31'b0, e_read});
    chk("inst_addr", inst_addr_o, e_addr);
    chk("ifid_load", {31'b0, ifid_load_o}, {31'b0, e_load});
    chk("ifid_flush", {31'b0, ifid_flush_o}, {31'b0, e_flush});
    chk("if_pc", if_pc_o, e_pc);
    chk("if_instr", if_instr_o, e_ins);
    last_load = ifid_load_o; last_flush = ifid_flush_o; last_read = inst_read_o;
    last_pc = if_pc_o; last_addr = inst_addr_o;
    if (!rv) model_reset();
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_read"}, {31'b0, inst_read_o}, 32'h0);
    chk({nm, "_addr"}, inst_addr_o, 32'h0);
    chk({nm, "_load"}, {31'b0, ifid_load_o}, 32'h0);
    chk({nm, "_pc"}, if_pc_o, 32'h0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // 1: responses every second cycle, sequential delivery.
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, (i % 2) == 1, 32'h0000_0013);
      if (i % 2 == 1) begin
        chk("t1_load", {31'b0, last_load}, 32'h1);
        chk("t1_pc", last_pc, RST_PC + 32'(4 * (i / 2)));
      end else begin
        chk("t1_addr", last_addr, RST_PC + 32'(4 * (i / 2)));
      end
    end

    // 2: stall on the response for 0x60000004.
    do_reset();
    step(1, 0, 0, 0, 1, 32'h1111_1111);
    chk("t2_pc0", last_pc, 32'h6000_0000);
    step(1, 1, 0, 0, 1, 32'h2222_2222);
    chk("t2_load_resp", {31'b0, last_load}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 0);
      chk("t2_load_hold", {31'b0, last_load}, 32'h0);
      chk("t2_read_hold", {31'b0, last_read}, 32'h0);
    end
    step(1, 0, 0, 0, 0, 0);
    chk("t2_release_load", {31'b0, last_load}, 32'h1);
    chk("t2_release_pc", last_pc, 32'h6000_0004);
    step(1, 0, 0, 0, 0, 0);
    chk("t2_next_addr", last_addr, 32'h6000_0008);

    // 3: redirect with request outstanding.
    step(1, 0, 1, 32'h6000_0102, 0, 0);
    chk("t3_flush", {31'b0, last_flush}, 32'h1);
    step(1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t3_drop_load", {31'b0, last_load}, 32'h0);
    chk("t3_stale_addr", last_addr, 32'h6000_0008);
    step(1, 0, 0, 0, 0, 0);
    chk("t3_new_addr", last_addr, 32'h6000_0100);

    // 4: redirect coinciding with a response.
    step(1, 0, 1, 32'h6000_0200, 1, 32'h3333_3333);
    chk("t4_flush", {31'b0, last_flush}, 32'h1);
    chk("t4_load", {31'b0, last_load}, 32'h0);
    step(1, 0, 0, 0, 0, 0);
    chk("t4_addr", last_addr, 32'h6000_0200);

    // 5: asynchronous reset mid-FETCH and mid-HOLD.
    @(posedge clk); #1 rst = 0; #1 chk_quiet("t5_fetch");
    model_reset();
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("t5_addr_after", last_addr, RST_PC);
    step(1, 1, 0, 0, 1, 32'h4444_4444);
    step(1, 1, 0, 0, 0, 0);
    @(posedge clk); #1 rst = 0; #1 chk_quiet("t5_hold");
    model_reset();
    step(0, 0, 0, 0, 0, 0);

    // 6: PC wraparound.
    step(1, 0, 1, 32'hFFFF_FFFF, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 32'h5555_5555);
    chk("t6_pc", last_pc, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0);
    chk("t6_wrap_addr", last_addr, 32'h0000_0000);
`ifdef IF_FETCH_PERF_EN
    chk("t6_fetch_cnt", fetch_cnt_o, 32'h1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bit rv, st, rd, rs;
      rv = ($urandom_range(0, 299) != 0);
      st = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 8);
      rs = ($urandom_range(0, 99) < 40);
      step(rv, st, rd, $urandom, rs, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
